// File: rtl/prgrom_loader_if.sv
// Byte-stream handshake between a byte source (e.g. UART RX) and the loader.
// A byte moves on a rising edge where byte_valid && byte_ready.
interface prgrom_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/prgrom_loader.sv
// Program-image loader: length header, little-endian word packing,
// one instruction-memory write per word, CPU held in reset meanwhile.
module prgrom_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  prgrom_loader_if.slave        bs,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q;
  logic [23:0]           shift_q;
  logic [1:0]            k_q;
  logic [ADDR_WIDTH:0]   word_q;
  logic [ADDR_WIDTH:0]   word_nx;
  logic [TW-1:0]         tmo_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;

  logic        ready;
  logic        acc;
  logic        go;
  logic        tmo_exp;
  logic        len_bad;
  logic        last;
  logic [15:0] len_full;

  assign ready   = (state_q == LEN_LO) ||
                   (state_q == LEN_HI) ||
                   (state_q == DATA);
  assign acc     = bs.byte_valid && ready;
  assign go      = start_i && ((state_q == IDLE) ||
                   (state_q == DONE) || (state_q == ERROR));
  assign tmo_exp = !acc && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign len_full = {bs.byte_data, len_q[7:0]};
  assign len_bad = (len_full == 16'd0) ||
                   (32'(len_full) > (32'd1 << ADDR_WIDTH));
  assign word_nx = word_q + 1'b1;
  assign last    = (32'(word_nx) == 32'(len_q));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i)           state_d = LEN_LO;
        else if (state_q == DONE) state_d = IDLE;
      end
      LEN_LO: begin
        if (acc)          state_d = LEN_HI;
        else if (tmo_exp) state_d = ERROR;
      end
      LEN_HI: begin
        if (acc)          state_d = len_bad ? ERROR : DATA;
        else if (tmo_exp) state_d = ERROR;
      end
      DATA: begin
        if (acc && k_q == 2'd3) state_d = WRITE;
        else if (tmo_exp)       state_d = ERROR;
      end
      WRITE:   state_d = last ? DONE : DATA;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bs.byte_ready = ready;
    wr_en_o       = (state_q == WRITE);
    done_o        = (state_q == DONE);
    err_o         = (state_q == ERROR);
    cpu_hold_o    = ready || (state_q == WRITE) ||
                    (state_q == ERROR);
    wr_addr_o     = wr_addr_q;
    wr_data_o     = wr_data_q;
  end

  // Bytes shift in from the top so byte 0 lands in bits [7:0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q     <= '0;
      shift_q   <= '0;
      k_q       <= '0;
      word_q    <= '0;
      tmo_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (go) begin
      k_q    <= '0;
      word_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (acc) begin
        tmo_q <= '0;
        unique case (state_q)
          LEN_LO: len_q[7:0]  <= bs.byte_data;
          LEN_HI: len_q[15:8] <= bs.byte_data;
          default: begin
            shift_q <= {bs.byte_data, shift_q[23:8]};
            k_q     <= k_q + 2'd1;
            if (k_q == 2'd3) begin
              wr_data_q <= {bs.byte_data, shift_q};
              wr_addr_q <= word_q[ADDR_WIDTH-1:0];
            end
          end
        endcase
      end else if (ready) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (state_q == WRITE) word_q <= word_nx;
    end
  end

endmodule

// File: tb/tb_prgrom_loader.sv
// Directed bench for prgrom_loader: header table plus
// hand-written multi-cycle load, timeout and reset sequences.
module tb_prgrom_loader;

  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;

  prgrom_loader_if bif ();

  prgrom_loader #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock     (clk),
    .reset     (rst_n),
    .start_i   (start),
    .bs        (bif.slave),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data),
    .cpu_hold_o(cpu_hold),
    .done_o    (done),
    .err_o     (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int done_cnt;
  int done_cyc;
  int last_wr_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      last_wr_cyc = cyc;
      chk("ready_in_write", 32'(bif.byte_ready), 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wa.delete();
    wd.delete();
    done_cnt    = 0;
    done_cyc    = -100;
    last_wr_cyc = -200;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clr();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    int   ok;
    ok = 0;
    bif.byte_valid = 1'b1;
    bif.byte_data  = b;
    for (int i = 0; i < 40; i++) begin
      r = bif.byte_ready;
      tick();
      if (r) begin
        ok = 1;
        break;
      end
    end
    bif.byte_valid = 1'b0;
    chk("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) tick();
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      if (done_cnt > 0) break;
      tick();
    end
    tick();
    tick();
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
    chk("hold_rel", 32'(cpu_hold), 32'd0);
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_err;
  } hdr_t;

  hdr_t vec[6];

  initial begin
    vec[0] = '{8'h00, 8'h00, 1'b1};
    vec[1] = '{8'h11, 8'h00, 1'b1};
    vec[2] = '{8'h10, 8'h00, 1'b0};
    vec[3] = '{8'h01, 8'h00, 1'b0};
    vec[4] = '{8'h00, 8'h01, 1'b1};
    vec[5] = '{8'hFF, 8'hFF, 1'b1};

    start          = 1'b0;
    bif.byte_valid = 1'b0;
    bif.byte_data  = 8'h00;
    clr();
    rst_n = 1'b0;
    #1;
    tick();
    chk("rst_outs",
        32'({wr_en, wr_addr, wr_data, cpu_hold,
             done, err, bif.byte_ready}), 32'd0);
    rst_n = 1'b1;
    tick();

    // header table
    foreach (vec[i]) begin
      do_reset();
      pulse_start();
      send_byte(vec[i].lo);
      send_byte(vec[i].hi);
      chk($sformatf("hdr%0d_err", i),
          32'(err), 32'(vec[i].exp_err));
      chk($sformatf("hdr%0d_rdy", i),
          32'(bif.byte_ready), 32'(!vec[i].exp_err));
      chk($sformatf("hdr%0d_hold", i),
          32'(cpu_hold), 32'd1);
    end

    // basic two-word image
    do_reset();
    pulse_start();
    chk("t1_hold", 32'(cpu_hold), 32'd1);
    chk("t1_rdy", 32'(bif.byte_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h0000_0013, 0);
    send_word(32'h1234_5678, 0);
    wait_done();
    chk("t1_nwr", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("t1_a0", 32'(wa[0]), 32'd0);
      chk("t1_d0", wd[0], 32'h0000_0013);
      chk("t1_a1", 32'(wa[1]), 32'd1);
      chk("t1_d1", wd[1], 32'h1234_5678);
    end
    chk("t1_hold_wr", 32'(wr_data), 32'h1234_5678);

    // zero-length header, then recovery
    do_reset();
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (30) tick();
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    chk("t2_nwr", 32'(wa.size()), 32'd0);
    pulse_start();
    chk("t2_errclr", 32'(err), 32'd0);
    chk("t2_rdy", 32'(bif.byte_ready), 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hDDCC_BBAA, 0);
    wait_done();
    chk("t2_nwr2", 32'(wa.size()), 32'd1);
    chk("t2_d0", wr_data, 32'hDDCC_BBAA);

    // timeout after two data bytes
    do_reset();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (TO - 1) tick();
    chk("t3_err15", 32'(err), 32'd0);
    tick();
    chk("t3_err16", 32'(err), 32'd1);
    chk("t3_nwr", 32'(wa.size()), 32'd0);

    // random gaps, three words
    do_reset();
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(32'hCAFE_0001, 5);
    send_word(32'hBEEF_0002, 5);
    send_word(32'h0BAD_F00D, 5);
    wait_done();
    chk("t4_nwr", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("t4_a2", 32'(wa[2]), 32'd2);
      chk("t4_d0", wd[0], 32'hCAFE_0001);
      chk("t4_d1", wd[1], 32'hBEEF_0002);
      chk("t4_d2", wd[2], 32'h0BAD_F00D);
    end

    // start mid-word ignored
    do_reset();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h5566_7788, 0);
    wait_done();
    chk("t5_nwr", 32'(wa.size()), 32'd2);
    chk("t5_d0", wd.size() > 0 ? wd[0] : 32'hX, 32'h0403_0201);
    chk("t5_err", 32'(err), 32'd0);

    // reset mid-word
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAB);
    send_byte(8'hCD);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs",
        32'({wr_en, wr_addr, wr_data, cpu_hold,
             done, err, bif.byte_ready}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    clr();
    pulse_start();
    chk("t5_relen", 32'(bif.byte_ready), 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h1357_9BDF, 0);
    wait_done();
    chk("t5_post", wr_data, 32'h1357_9BDF);

    // full memory, len == 2**AW
    do_reset();
    pulse_start();
    send_byte(8'h10);
    send_byte(8'h00);
    for (int w = 0; w < 16; w++)
      send_word(32'hA5000000 | 32'(w * 3), 0);
    wait_done();
    chk("t6_nwr", 32'(wa.size()), 32'd16);
    if (wa.size() == 16) begin
      for (int w = 0; w < 16; w++) begin
        chk("t6_addr", 32'(wa[w]), 32'(w));
        chk("t6_data", wd[w], 32'hA5000000 | 32'(w * 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
